// File: rtl/csa_pkg.sv
// Shared constants and types for the carry-save accumulator slice.
package csa_pkg;

    localparam int W      = 88;
    localparam int CHUNK  = 22;
    localparam int NCHUNK = 4;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_e;

    typedef struct packed {
        logic [W-1:0] c;
        logic [W-1:0] s;
    } csa_pair_t;

endpackage

// File: rtl/csa_88.sv
// 88-bit 3:2 carry-save compressor; carry vector is pre-shifted left, top carry dropped.
module csa_88
    import csa_pkg::*;
(
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);

    logic [W-1:0] maj_s;

    assign s     = x ^ y ^ z;
    assign maj_s = (x & y) | (x & z) | (y & z);
    assign c     = {maj_s[W-2:0], 1'b0};

endmodule

// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator: folds a programmed number of terms into a redundant
// (sum, carry) pair, then resolves it to binary with a chunked carry-propagate add.
module csa_accum_ctrl
    import csa_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_terms,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    input  logic             out_ready,
    output logic             busy
);

    state_e            state_r;
    csa_pair_t         pair_r;
    logic [W-1:0]      result_r;
    logic [CNT_W-1:0]  remaining_r;
    logic [1:0]        chunk_idx_r;
    logic              cin_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [W-1:0]      out_data_r;
    logic              busy_r;

    logic [W-1:0]      csa_s_s;
    logic [W-1:0]      csa_c_s;
    logic [CHUNK-1:0]  s_chunk_s;
    logic [CHUNK-1:0]  c_chunk_s;
    logic [CHUNK:0]    chunk_sum_s;
    logic [W-1:0]      result_next_s;
    logic              accept_s;

    csa_88 u_csa (
        .x (pair_r.s),
        .y (pair_r.c),
        .z (in_data),
        .s (csa_s_s),
        .c (csa_c_s)
    );

    // in_ready_r is only ever high in ACCUM, so no path from in_valid to in_ready
    assign accept_s = in_valid & in_ready_r;

    // Chunk select and carry-propagate add for the current resolve step
    always_comb begin
        s_chunk_s     = {CHUNK{1'b0}};
        c_chunk_s     = {CHUNK{1'b0}};
        result_next_s = result_r;
        case (chunk_idx_r)
            2'd0: begin
                s_chunk_s = pair_r.s[0*CHUNK +: CHUNK];
                c_chunk_s = pair_r.c[0*CHUNK +: CHUNK];
            end
            2'd1: begin
                s_chunk_s = pair_r.s[1*CHUNK +: CHUNK];
                c_chunk_s = pair_r.c[1*CHUNK +: CHUNK];
            end
            2'd2: begin
                s_chunk_s = pair_r.s[2*CHUNK +: CHUNK];
                c_chunk_s = pair_r.c[2*CHUNK +: CHUNK];
            end
            2'd3: begin
                s_chunk_s = pair_r.s[3*CHUNK +: CHUNK];
                c_chunk_s = pair_r.c[3*CHUNK +: CHUNK];
            end
            default: begin
                s_chunk_s = {CHUNK{1'b0}};
                c_chunk_s = {CHUNK{1'b0}};
            end
        endcase
        chunk_sum_s = {1'b0, s_chunk_s} + {1'b0, c_chunk_s} + {{CHUNK{1'b0}}, cin_r};
        case (chunk_idx_r)
            2'd0:    result_next_s[0*CHUNK +: CHUNK] = chunk_sum_s[CHUNK-1:0];
            2'd1:    result_next_s[1*CHUNK +: CHUNK] = chunk_sum_s[CHUNK-1:0];
            2'd2:    result_next_s[2*CHUNK +: CHUNK] = chunk_sum_s[CHUNK-1:0];
            2'd3:    result_next_s[3*CHUNK +: CHUNK] = chunk_sum_s[CHUNK-1:0];
            default: result_next_s = result_r;
        endcase
    end

    // Sequencer FSM with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            pair_r.s    <= {W{1'b0}};
            pair_r.c    <= {W{1'b0}};
            result_r    <= {W{1'b0}};
            remaining_r <= {CNT_W{1'b0}};
            chunk_idx_r <= 2'd0;
            cin_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {W{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        busy_r <= 1'b1;
                        if (n_terms != {CNT_W{1'b0}}) begin
                            remaining_r <= n_terms;
                            pair_r.s    <= {W{1'b0}};
                            pair_r.c    <= {W{1'b0}};
                            in_ready_r  <= 1'b1;
                            state_r     <= ACCUM;
                        end else begin
                            result_r    <= {W{1'b0}};
                            out_data_r  <= {W{1'b0}};
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end
                    end
                end
                ACCUM: begin
                    if (accept_s) begin
                        pair_r.s    <= csa_s_s;
                        pair_r.c    <= csa_c_s;
                        remaining_r <= remaining_r - {{(CNT_W-1){1'b0}}, 1'b1};
                        if (remaining_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            in_ready_r  <= 1'b0;
                            chunk_idx_r <= 2'd0;
                            cin_r       <= 1'b0;
                            state_r     <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    result_r    <= result_next_s;
                    cin_r       <= chunk_sum_s[CHUNK];
                    chunk_idx_r <= chunk_idx_r + 2'd1;
                    // Carry out of the top chunk is discarded: result is modulo 2^W
                    if (chunk_idx_r == 2'd3) begin
                        cin_r       <= 1'b0;
                        out_data_r  <= result_next_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;

endmodule
